// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order instruction memory reads,
// buffers returned words and presents them to decode. Honours stall,
// redirect (pc_sel) with wrong-path response dropping, and registers the
// exe-side false_path indication into squash_de.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  input  logic        false_path,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instr_fetch,
  output logic [31:0] pc_fetch,
  output logic [31:0] pc_4_fetch,
  output logic        squash_de
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];

  logic [CW:0]   occupancy;
  logic          handshake;
  logic          rsp;
  logic          dropping;
  logic          push_en;
  logic          pop_en;
  logic [31:0]   resp_pc;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffer head drives decode directly; PC tracks the fetch PC when empty.
  always_comb begin
    fetch_valid = (count_q != '0);
    instr_fetch = fetch_valid ? buf_instr[rd_ptr_q] : NOP_INSTR;
    pc_fetch    = fetch_valid ? buf_pc[rd_ptr_q] : pc_q;
    pc_4_fetch  = pc_fetch + 32'd4;
  end

  // Issue, response accounting, buffer control and next-state logic.
  always_comb begin
    occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    imem_req  = (state_q == S_RUN) && (occupancy < (CW + 1)'(FIFO_DEPTH)) && !pc_sel && !rst;
    imem_addr = pc_q;
    handshake = imem_req && imem_gnt;

    // A response with nothing outstanding is stale (e.g. from before reset).
    rsp       = imem_rvalid && (inflight_q != '0);
    dropping  = rsp && (drop_q != '0);
    push_en   = rsp && !dropping && !pc_sel;
    pop_en    = fetch_valid && !stall && !pc_sel;

    // Surviving in-flight requests are consecutive words ending just below
    // pc_q, so the oldest one's PC is recovered without per-request storage.
    resp_pc   = pc_q - (32'(inflight_q) << 2);

    state_d    = state_q;
    pc_d       = handshake ? pc_q + 32'd4 : pc_q;
    inflight_d = inflight_q + CW'(handshake) - CW'(rsp);
    drop_d     = drop_q - CW'(dropping);
    rd_ptr_d   = pop_en  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push_en ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d    = count_q + CW'(push_en) - CW'(pop_en);

    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FLUSH: if (drop_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    if (pc_sel) begin
      pc_d     = target_pc & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = inflight_d;
      state_d  = (inflight_d != '0) ? S_FLUSH : S_RUN;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; the credit rule guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      assert (count_q < CW'(FIFO_DEPTH));
      buf_instr[wr_ptr_q] <= imem_rdata;
      buf_pc[wr_ptr_q]    <= resp_pc;
    end
  end

  // One-cycle registered squash of the decode register.
  always_ff @(posedge clk) begin
    if (rst) squash_de <= 1'b0;
    else     squash_de <= false_path;
  end

endmodule
